jt08_adpcm_ramarb: RTL and testbench

- Two-port arbiter for the single external ADPCM-B sample RAM port (21-bit byte address, 8-bit data).
- Port 0 serves the ADPCM-B driver: playback fetches and CPU RAM read/write.
- Port 1 serves a secondary requester, e.g. the FDD/system DMA sharing the same physical memory.
- Replaces fixed extra read-wait padding with an explicit request/acknowledge handshake plus a timeout guard, so neither side needs to assume a fixed memory latency.

---
 rtl/jt08_adpcm_pkg.sv | 15 +
 rtl/jt08_ramarb_pick.sv | 23 ++
 rtl/jt08_adpcm_ramarb.sv | 162 ++++++++++++++++
 tb/tb_jt08_adpcm_ramarb.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jt08_adpcm_pkg.sv
// rtl/jt08_adpcm_pkg.sv - shared constants for the ADPCM-B sample RAM arbiter
package jt08_adpcm_pkg;

  localparam int AW_DEF = 21;

  localparam logic [7:0] TMO_FILL = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/jt08_ramarb_pick.sv
// rtl/jt08_ramarb_pick.sv - combinational grant selector for the two RAM requesters
module jt08_ramarb_pick #(
  parameter bit PRIO0 = 1'b1
) (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,
  output logic g_o,
  output logic valid_o
);

  always_comb begin
    valid_o = req0_i | req1_i;
    g_o     = 1'b0;
    if (req0_i && req1_i) begin
      // On a tie the round-robin mode hands the grant to whoever did not win last.
      g_o = PRIO0 ? 1'b0 : ~last_i;
    end else if (req1_i) begin
      g_o = 1'b1;
    end
  end

endmodule

// File: rtl/jt08_adpcm_ramarb.sv
// rtl/jt08_adpcm_ramarb.sv - two-port req/ack arbiter for the external ADPCM-B sample RAM
module jt08_adpcm_ramarb
  import jt08_adpcm_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int TIMEOUT = 15,
  parameter bit PRIO0   = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [7:0]    wdata0,
  output logic [7:0]    rdata0,
  output logic          ack0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [7:0]    wdata1,
  output logic [7:0]    rdata1,
  output logic          ack1,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  input  logic          mem_ack,
  output logic          busy,
  output logic          tmo
);

  localparam logic [7:0] TMO_CNT = 8'(TIMEOUT);

  arb_state_t    state_q, state_d;
  logic          g_q, g_d;
  logic          last_q, last_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          mem_req_q, mem_req_d;
  logic          busy_q, busy_d;
  logic          tmo_q, tmo_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]    mem_wdata_q, mem_wdata_d;
  logic [7:0]    rdata0_q, rdata0_d;
  logic [7:0]    rdata1_q, rdata1_d;

  logic pick_g;
  logic pick_valid;

  jt08_ramarb_pick #(
    .PRIO0 (PRIO0)
  ) u_pick (
    .req0_i  (req0),
    .req1_i  (req1),
    .last_i  (last_q),
    .g_o     (pick_g),
    .valid_o (pick_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      g_q         <= 1'b0;
      last_q      <= 1'b1;
      cnt_q       <= 8'd0;
      mem_req_q   <= 1'b0;
      busy_q      <= 1'b0;
      tmo_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'd0;
      rdata0_q    <= 8'd0;
      rdata1_q    <= 8'd0;
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      busy_q      <= busy_d;
      tmo_q       <= tmo_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    busy_d      = busy_q;
    tmo_d       = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          // Command fields are frozen here; later requester changes do not reach memory.
          g_d         = pick_g;
          mem_we_d    = pick_g ? we1 : we0;
          mem_addr_d  = pick_g ? addr1 : addr0;
          mem_wdata_d = pick_g ? wdata1 : wdata0;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        mem_req_d = 1'b1;
        busy_d    = 1'b1;
        cnt_d     = 8'd0;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (!mem_we_q) begin
            if (g_q) rdata1_d = mem_rdata;
            else     rdata0_d = mem_rdata;
          end
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == TMO_CNT) begin
            // Force completion so a dead memory cannot stall playback forever.
            mem_req_d = 1'b0;
            tmo_d     = 1'b1;
            if (g_q) rdata1_d = TMO_FILL;
            else     rdata0_d = TMO_FILL;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        last_d  = g_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ack0      = (state_q == ST_DONE) && !g_q;
  assign ack1      = (state_q == ST_DONE) &&  g_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign tmo       = tmo_q;

endmodule

// File: tb/tb_jt08_adpcm_ramarb.sv
// tb/tb_jt08_adpcm_ramarb.sv - directed bench for the ADPCM-B RAM arbiter
module tb_jt08_adpcm_ramarb;

  localparam int AW = 21;

  logic          clk;
  logic          rst_n;
  logic          req0_a, req1_a, req0_b, req1_b;
  logic          we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [7:0]    wdata0, wdata1;
  logic [7:0]    mem_rdata;
  logic [1:0]    mack;
  logic [1:0]    ack_en;
  logic [1:0]    seen;

  wire [7:0]    rdata0_a, rdata1_a, rdata0_b, rdata1_b;
  wire          ack0_a, ack1_a, ack0_b, ack1_b;
  wire [1:0]    mreq;
  wire          mem_we_a, mem_we_b, busy_a, busy_b, tmo_a, tmo_b;
  wire [AW-1:0] mem_addr_a, mem_addr_b;
  wire [7:0]    mem_wdata_a, mem_wdata_b;

  int checks;
  int failures;

  jt08_adpcm_ramarb #(.AW(AW), .TIMEOUT(15), .PRIO0(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req0(req0_a), .we0(we0), .addr0(addr0), .wdata0(wdata0), .rdata0(rdata0_a), .ack0(ack0_a),
    .req1(req1_a), .we1(we1), .addr1(addr1), .wdata1(wdata1), .rdata1(rdata1_a), .ack1(ack1_a),
    .mem_req(mreq[0]), .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
    .mem_rdata(mem_rdata), .mem_ack(mack[0]), .busy(busy_a), .tmo(tmo_a)
  );

  jt08_adpcm_ramarb #(.AW(AW), .TIMEOUT(15), .PRIO0(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req0(req0_b), .we0(we0), .addr0(addr0), .wdata0(wdata0), .rdata0(rdata0_b), .ack0(ack0_b),
    .req1(req1_b), .we1(we1), .addr1(addr1), .wdata1(wdata1), .rdata1(rdata1_b), .ack1(ack1_b),
    .mem_req(mreq[1]), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_rdata(mem_rdata), .mem_ack(mack[1]), .busy(busy_b), .tmo(tmo_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: acknowledges one cycle after it first sees mem_req.
  initial begin
    mack = 2'b00;
    seen = 2'b00;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (mack[i]) begin
          mack[i] = 1'b0;
          seen[i] = 1'b0;
        end else if (mreq[i] && ack_en[i]) begin
          if (seen[i]) mack[i] = 1'b1;
          else         seen[i] = 1'b1;
        end else begin
          seen[i] = 1'b0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input bit sel, output bit got, output logic a0, output logic a1);
    got = 1'b0;
    a0  = 1'b0;
    a1  = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tick();
      a0 = sel ? ack0_b : ack0_a;
      a1 = sel ? ack1_b : ack1_a;
      if (a0 || a1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_contention(input bit sel, output logic [2:0] grants);
    bit   got;
    logic a0, a1;
    grants = 3'b000;
    @(negedge clk);
    if (sel) begin req0_b = 1'b1; req1_b = 1'b1; end
    else     begin req0_a = 1'b1; req1_a = 1'b1; end
    for (int k = 0; k < 3; k++) begin
      wait_ack(sel, got, a0, a1);
      check("cont_ack_seen", 32'(got), 32'd1);
      check("cont_ack_onehot", 32'(a0 & a1), 32'd0);
      grants[k] = a1;
    end
    @(negedge clk);
    req0_a = 1'b0; req1_a = 1'b0; req0_b = 1'b0; req1_b = 1'b0;
    tick();
    tick();
  endtask

  logic [2:0] grants;
  bit         got;
  logic       a0, a1;

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    req0_a = 1'b0; req1_a = 1'b0; req0_b = 1'b0; req1_b = 1'b0;
    we0 = 1'b0; we1 = 1'b0; addr0 = '0; addr1 = '0; wdata0 = 8'd0; wdata1 = 8'd0;
    mem_rdata = 8'd0;
    ack_en = 2'b11;
    tick();
    tick();
    check("rst_mem_req", 32'(mreq[0]), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_acks", 32'({ack0_a, ack1_a}), 32'd0);
    check("rst_mem_addr", 32'(mem_addr_a), 32'd0);
    check("rst_rdata", 32'({rdata0_a, rdata1_a}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Round-robin alternates starting from port 0; fixed priority always picks port 0.
    run_contention(1'b0, grants);
    check("cont_rr_grants", 32'(grants), 32'b010);
    run_contention(1'b1, grants);
    check("cont_prio_grants", 32'(grants), 32'b000);

    // Single read on port 0
    @(negedge clk);
    req0_a = 1'b1; we0 = 1'b0; addr0 = 21'h00123; mem_rdata = 8'hA5;
    tick();
    check("rd_issue_mem_req", 32'(mreq[0]), 32'd0);
    check("rd_mem_addr", 32'(mem_addr_a), 32'h00123);
    tick();
    check("rd_mem_req", 32'(mreq[0]), 32'd1);
    check("rd_busy", 32'(busy_a), 32'd1);
    check("rd_mem_we", 32'(mem_we_a), 32'd0);
    tick();
    check("rd_no_early_ack", 32'(ack0_a), 32'd0);
    tick();
    check("rd_ack0", 32'({ack0_a, ack1_a}), 32'b10);
    check("rd_rdata0", 32'(rdata0_a), 32'hA5);
    check("rd_mem_req_drop", 32'(mreq[0]), 32'd0);
    @(negedge clk);
    req0_a = 1'b0;
    tick();
    check("rd_idle_ack", 32'(ack0_a), 32'd0);
    check("rd_idle_busy", 32'(busy_a), 32'd0);

    // Write on port 1
    @(negedge clk);
    req1_a = 1'b1; we1 = 1'b1; addr1 = 21'h1FFFFF; wdata1 = 8'h3C;
    tick();
    check("wr_mem_we", 32'(mem_we_a), 32'd1);
    check("wr_mem_wdata", 32'(mem_wdata_a), 32'h3C);
    check("wr_mem_addr", 32'(mem_addr_a), 32'h1FFFFF);
    tick();
    tick();
    tick();
    check("wr_ack1", 32'({ack0_a, ack1_a}), 32'b01);
    check("wr_rdata1_kept", 32'(rdata1_a), 32'h00);
    check("wr_rdata0_kept", 32'(rdata0_a), 32'hA5);
    @(negedge clk);
    req1_a = 1'b0; we1 = 1'b0;
    tick();

    // Timeout with memory silent
    @(negedge clk);
    ack_en[0] = 1'b0; req0_a = 1'b1; addr0 = 21'h00055;
    tick();
    tick();
    repeat (14) tick();
    check("tmo_wait15_req", 32'(mreq[0]), 32'd1);
    check("tmo_wait15_tmo", 32'(tmo_a), 32'd0);
    tick();
    check("tmo_req_drop", 32'(mreq[0]), 32'd0);
    check("tmo_pulse", 32'(tmo_a), 32'd1);
    check("tmo_ack0", 32'(ack0_a), 32'd1);
    check("tmo_rdata0", 32'(rdata0_a), 32'hFF);
    @(negedge clk);
    req0_a = 1'b0; ack_en[0] = 1'b1;
    tick();
    check("tmo_idle", 32'({tmo_a, busy_a, ack0_a}), 32'd0);

    // Port 1 queues behind an in-flight port 0 read
    @(negedge clk);
    req0_a = 1'b1; addr0 = 21'h00010; mem_rdata = 8'h5A;
    tick();
    tick();
    @(negedge clk);
    req1_a = 1'b1; addr1 = 21'h00020;
    tick();
    tick();
    check("q_ack0", 32'({ack0_a, ack1_a}), 32'b10);
    check("q_rdata0", 32'(rdata0_a), 32'h5A);
    @(negedge clk);
    req0_a = 1'b0;
    tick();
    check("q_idle_acks", 32'({ack0_a, ack1_a}), 32'b00);
    @(negedge clk);
    mem_rdata = 8'hC3;
    tick();
    check("q_grant1_addr", 32'(mem_addr_a), 32'h00020);
    wait_ack(1'b0, got, a0, a1);
    check("q_ack1_seen", 32'({got, a0, a1}), 32'b101);
    check("q_rdata1", 32'(rdata1_a), 32'hC3);
    @(negedge clk);
    req1_a = 1'b0;
    tick();

    // Reset while waiting on memory
    @(negedge clk);
    ack_en[0] = 1'b0; req0_a = 1'b1;
    tick();
    tick();
    check("mr_in_wait", 32'(mreq[0]), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mr_async", 32'({mreq[0], busy_a, ack0_a, ack1_a}), 32'd0);
    tick();
    check("mr_next_acks", 32'({ack0_a, ack1_a}), 32'd0);
    @(negedge clk);
    req0_a = 1'b0; rst_n = 1'b1; ack_en[0] = 1'b1;
    tick();
    check("mr_after", 32'({mreq[0], busy_a, ack0_a}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
